// File: rtl/cyclic_code_pkg.sv
// Shared constants, FSM state type and polynomial helper for the (7,4) cyclic code.
package cyclic_code_pkg;

  localparam int unsigned N     = 7;
  localparam int unsigned K     = 4;
  localparam logic [3:0]  GPOLY = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CORR
  } state_t;

  // x^n mod g(x); gpoly carries the x^deg term, result occupies bits [deg-1:0].
  function automatic logic [31:0] polymod_xpow(input int unsigned n,
                                               input logic [31:0] gpoly,
                                               input int unsigned deg = N - K);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r << 1;
      if (r[deg]) r = r ^ gpoly;
    end
    return r;
  endfunction

endpackage

// File: rtl/cyclic_decoder_serial_if.sv
// Bit-serial handshake bundle between front end, decoder and data sink.
interface cyclic_decoder_serial_if;
  logic in_valid;
  logic in_ready;
  logic in;
  logic out_valid;
  logic out_ready;
  logic out;
  logic err;
  logic done;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, err, done
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, err, done
  );
endinterface

// File: rtl/cyclic_syndrome_lfsr.sv
// Divide-by-g(x) register: load feeds a new dividend bit, shift multiplies by x, clear zeroes.
module cyclic_syndrome_lfsr
  import cyclic_code_pkg::*;
#(
  parameter int unsigned W    = N - K,
  parameter logic [W:0]  POLY = GPOLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] s,
  output logic [W-1:0] s_next
);

  logic [W-1:0] s_mulx;

  assign s_mulx = {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY[W-1:0] : '0);

  always_comb begin
    s_next = s;
    if (clear)      s_next = '0;
    else if (load)  s_next = s_mulx ^ {{(W-1){1'b0}}, din};
    else if (shift) s_next = s_mulx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s <= '0;
    else        s <= s_next;
  end

endmodule

// File: rtl/cyclic_decoder_serial.sv
// Serial Meggitt decoder for the (N,K) cyclic code generated by GPOLY.
// Optional macro CYCLIC_DEC_STATS_EN adds a saturating err_count output.
module cyclic_decoder_serial
  import cyclic_code_pkg::*;
#(
  parameter int unsigned   N     = cyclic_code_pkg::N,
  parameter int unsigned   K     = cyclic_code_pkg::K,
  parameter logic [N-K:0]  GPOLY = cyclic_code_pkg::GPOLY
) (
  input  logic                    clk,
  input  logic                    reset,
  cyclic_decoder_serial_if.slave  bus
`ifdef CYCLIC_DEC_STATS_EN
  , output logic [15:0]           err_count
`endif
);

  localparam int unsigned  M   = N - K;
  localparam int unsigned  CW  = $clog2(N + 1);
  localparam logic [M-1:0] PAT = M'(polymod_xpow(N - 1, 32'(GPOLY), M));

  state_t        state, state_nx;
  logic [N-1:0]  sh_buf;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          live_q;
  logic [M-1:0]  s, s_nx;

  logic rx_en, tx_en, in_fire, out_fire, done_c;
  logic last_in, last_out, hit;
  logic lf_clear, lf_load, lf_shift;

  assign last_in  = (cnt == CW'(N - 1));
  assign last_out = (cnt == CW'(K - 1));
  assign hit      = (s == PAT);
  assign in_fire  = bus.in_valid & rx_en;
  assign out_fire = tx_en & bus.out_ready;

  cyclic_syndrome_lfsr #(
    .W    (M),
    .POLY (GPOLY)
  ) u_syn (
    .clk    (clk),
    .reset  (reset),
    .clear  (lf_clear),
    .load   (lf_load),
    .shift  (lf_shift),
    .din    (bus.in),
    .s      (s),
    .s_next (s_nx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_fire)              state_nx = RECV;
      RECV:    if (in_fire && last_in)   state_nx = CORR;
      CORR:    if (out_fire && last_out) state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // A syndrome hit zeroes the register, and the last beat clears it so a
  // miscorrected multi-bit word leaves nothing behind for the next word.
  always_comb begin
    rx_en    = 1'b0;
    tx_en    = 1'b0;
    done_c   = 1'b0;
    lf_load  = 1'b0;
    lf_shift = 1'b0;
    lf_clear = 1'b0;
    case (state)
      IDLE, RECV: begin
        rx_en   = live_q;
        lf_load = bus.in_valid & live_q;
      end
      CORR: begin
        tx_en = 1'b1;
        if (bus.out_ready) begin
          done_c   = last_out;
          lf_clear = hit | last_out;
          lf_shift = ~(hit | last_out);
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = rx_en;
  assign bus.out_valid = tx_en;
  assign bus.out       = tx_en & (sh_buf[N-1] ^ hit);
  assign bus.err       = err_q;
  assign bus.done      = done_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_buf <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (in_fire) begin
        sh_buf <= {sh_buf[N-2:0], bus.in};
        cnt    <= last_in ? '0 : cnt + 1'b1;
      end else if (out_fire) begin
        sh_buf <= {sh_buf[N-2:0], 1'b0};
        cnt    <= last_out ? '0 : cnt + 1'b1;
      end
      if (in_fire && state == RECV && last_in) err_q <= |s_nx;
      else if (done_c)                         err_q <= 1'b0;
    end
  end

`ifdef CYCLIC_DEC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 err_count <= '0;
    else if (done_c && err_q && err_count != '1) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cyclic_decoder_serial.sv
// Self-checking bench for cyclic_decoder_serial: directed words, 1000 random words, mid-word reset.
module tb_cyclic_decoder_serial;

  localparam int N = 7;
  localparam int K = 4;

  typedef struct {
    logic [3:0] msg;
    logic       err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   beat   = 0;
  int   tally  = 0;
  bit   rand_mode = 0;
  exp_t exp_q[$];

  cyclic_decoder_serial_if bus();

`ifdef CYCLIC_DEC_STATS_EN
  logic [15:0] err_count;
`endif

  cyclic_decoder_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CYCLIC_DEC_STATS_EN
    , .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Remainder of a 7-bit polynomial by x^3+x+1, by long division.
  function automatic logic [2:0] polyrem(input logic [6:0] v);
    logic [6:0] r;
    r = v;
    for (int i = 6; i >= 3; i--)
      if (r[i]) r = r ^ (7'b0001011 << (i - 3));
    return r[2:0];
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] m);
    return {m, polyrem({m, 3'b000})};
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(bus.out_valid), 32'(0));
        end else begin
          exp_t e;
          e = exp_q[0];
          chk("out", 32'(bus.out), 32'(e.msg[K-1-beat]));
          chk("err", 32'(bus.err), 32'(e.err));
          if (beat == K - 1) begin
            chk("done_last", 32'(bus.done), 32'(1));
            chk("in_ready_on_done", 32'(bus.in_ready), 32'(0));
            if (e.err) tally++;
            void'(exp_q.pop_front());
            beat = 0;
          end else begin
            chk("done_early", 32'(bus.done), 32'(0));
            beat++;
          end
        end
      end else begin
        chk("done_stray", 32'(bus.done), 32'(0));
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    bus.in_valid = 1'b1;
    bus.in       = b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (rand_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_word(input logic [6:0] cw, input logic [3:0] msg, input logic err);
    exp_t e;
    e.msg = msg;
    e.err = err;
    exp_q.push_back(e);
    for (int i = N - 1; i >= 0; i--) send_bit(cw[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    beat = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(0));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    chk({tag, "_out"},       32'(bus.out),       32'(0));
    chk({tag, "_err"},       32'(bus.err),       32'(0));
    chk({tag, "_done"},      32'(bus.done),      32'(0));
  endtask

  initial begin
    logic [3:0] m;
    logic [6:0] cw;
    int unsigned e;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;

    chk("pin_enc_1001", 32'(encode(4'b1001)), 32'(7'b1001110));
    chk("pin_enc_0000", 32'(encode(4'b0000)), 32'(7'b0000000));
    chk("pin_syn_b6",   32'(polyrem(7'b0001110)), 32'(3'b101));
    chk("pin_syn_b4",   32'(polyrem(7'b1011110)), 32'(3'b110));
    chk("pin_syn_b0",   32'(polyrem(7'b1001111)), 32'(3'b001));

    repeat (3) @(negedge clk);
    chk_quiet("rst");
    reset = 1'b1;
    #1;
    chk("in_ready_pre_edge", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    chk("in_ready_post_edge", 32'(bus.in_ready), 32'(1));

    send_word(7'b0000000, 4'b0000, 1'b0);
    send_word(7'b1001110, 4'b1001, 1'b0);
    send_word(7'b0001110, 4'b1001, 1'b1);
    send_word(7'b1011110, 4'b1001, 1'b1);
    send_word(7'b1001111, 4'b1001, 1'b1);
    wait_idle();

    rand_mode = 1;
    for (int w = 0; w < 1000; w++) begin
      m  = 4'($urandom_range(0, 15));
      cw = encode(m);
      e  = $urandom_range(0, 7);
      if (e < 7) cw = cw ^ (7'b0000001 << e);
      send_word(cw, m, e < 7);
    end
    wait_idle();
    rand_mode = 0;

    // Abandon a word after three bits, then send a clean word.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    chk_quiet("midrst");
    tally = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_word(7'b1001110, 4'b1001, 1'b0);
    send_word(7'b1011110, 4'b1001, 1'b1);
    wait_idle();

`ifdef CYCLIC_DEC_STATS_EN
    chk("err_count", 32'(err_count), 32'(tally));
    chk("err_count_lit", 32'(err_count), 32'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
